// File: rtl/key_schedule_sequencer_if.sv
// Key-schedule sequencer bus.
//   i_start / i_key        start request and cipher key (word0 at [127:96])
//   i_roundKeyReady        consumer accepts the current round key
//   o_roundKey             round key {w0,w1,w2,w3}, w0 at [127:96]
//   o_roundNumber          round index of o_roundKey
//   o_roundKeyValid        o_roundKey / o_roundNumber valid
//   o_busy / o_done        expansion in progress / one-cycle completion pulse
//   o_state                FSM state, for observation only
// Handshake: a key moves when o_roundKeyValid & i_roundKeyReady are both high
// on a rising edge; while valid is high and ready is low, o_roundKey and
// o_roundNumber hold unchanged; ready is ignored while valid is low.
interface key_schedule_sequencer_if;
  logic         i_start;
  logic [127:0] i_key;
  logic         i_roundKeyReady;
  logic [127:0] o_roundKey;
  logic [3:0]   o_roundNumber;
  logic         o_roundKeyValid;
  logic         o_busy;
  logic         o_done;
  logic [1:0]   o_state;

  modport slave (
    input  i_start, i_key, i_roundKeyReady,
    output o_roundKey, o_roundNumber, o_roundKeyValid, o_busy, o_done, o_state
  );

  modport master (
    output i_start, i_key, i_roundKeyReady,
    input  o_roundKey, o_roundNumber, o_roundKeyValid, o_busy, o_done, o_state
  );
endinterface

// File: rtl/key_schedule_sequencer.sv
// AES-128 key-expansion sequencer. Latches a cipher key on start and emits one
// round key per accepted handshake for rounds 0 (optional) .. NR, then pulses
// done. Rcon is carried in a register advanced by xtime.
// Ports:
//   i_clk    rising-edge clock
//   i_reset  synchronous active-high reset, priority over everything
//   bus      key_schedule_sequencer_if.slave (start/key in, round keys out)
// Parameters:
//   NR           last round index (only 10 is meaningful)
//   EMIT_ROUND0  1: cipher key is emitted as round 0; 0: first key is round 1
module key_schedule_sequencer #(
  parameter int NR          = 10,
  parameter bit EMIT_ROUND0 = 1'b1
) (
  input logic                      i_clk,
  input logic                      i_reset,
  key_schedule_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EMIT   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // Byte b lives at bit offset (255-b)*8, which is {~b, 3'b000}.
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_TABLE[idx +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, t;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
          ^ {rc, 24'h0};
    w0  = w0 ^ t;
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [1:0]   state;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic [7:0]   rcon_q;     // rcon that builds the next round from key_q
  logic [127:0] key_from_reg;
  logic [127:0] key_from_in;
  logic         transfer;

  assign key_from_reg = next_key(key_q, rcon_q);
  // Round 1 straight from the input key, used when round 0 is not emitted.
  assign key_from_in  = next_key(bus.i_key, 8'h01);
  assign transfer     = (state == ST_EMIT) && bus.i_roundKeyReady;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            state <= ST_EMIT;
            if (EMIT_ROUND0) begin
              key_q   <= bus.i_key;
              round_q <= 4'd0;
              rcon_q  <= 8'h01;
            end else begin
              // Round 1 already consumed rcon 01.
              key_q   <= key_from_in;
              round_q <= 4'd1;
              rcon_q  <= xtime(8'h01);
            end
          end
        end
        ST_EMIT: begin
          if (transfer) begin
            if (round_q == LAST_ROUND) begin
              state <= ST_FINISH;
            end else begin
              key_q   <= key_from_reg;
              round_q <= round_q + 4'd1;
              rcon_q  <= xtime(rcon_q);
            end
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_roundKey      = key_q;
  assign bus.o_roundNumber   = round_q;
  assign bus.o_roundKeyValid = (state == ST_EMIT);
  assign bus.o_busy          = (state == ST_EMIT);
  assign bus.o_done          = (state == ST_FINISH);
  assign bus.o_state         = state;

endmodule

// File: tb/tb_key_schedule_sequencer.sv
module tb_key_schedule_sequencer;

  logic i_clk;
  logic i_reset;

  key_schedule_sequencer_if ks_a ();
  key_schedule_sequencer_if ks_b ();

  key_schedule_sequencer #(.NR(10), .EMIT_ROUND0(1'b1)) dut_a (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (ks_a.slave)
  );

  key_schedule_sequencer #(.NR(10), .EMIT_ROUND0(1'b0)) dut_b (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (ks_b.slave)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  logic [127:0] fips_rk [0:10];
  logic [127:0] exp_rk  [0:10];
  logic         exp_ok  [0:10];
  logic [127:0] exp_q [$];

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_JUNK = 128'hdeadbeef0123456789abcdeffedcba98;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_key"},   ks_a.o_roundKey, 128'h0);
    chk({tag, "_round"}, 128'(ks_a.o_roundNumber), 128'h0);
    chk({tag, "_valid"}, 128'(ks_a.o_roundKeyValid), 128'h0);
    chk({tag, "_busy"},  128'(ks_a.o_busy), 128'h0);
    chk({tag, "_done"},  128'(ks_a.o_done), 128'h0);
  endtask

  task automatic start_a(input logic [127:0] key);
    ks_a.i_key   = key;
    ks_a.i_start = 1'b1;
    tick();
    ks_a.i_start = 1'b0;
  endtask

  // Walk dut_a from round r0 to 10 with ready high; optionally pulse a stray
  // start with a different key while round inj_r is on the bus.
  task automatic walk_a(input string tag, input int r0, input int inj_r);
    ks_a.i_roundKeyReady = 1'b1;
    for (int r = r0; r <= 10; r++) begin
      chk({tag, "_valid"}, 128'(ks_a.o_roundKeyValid), 128'h1);
      chk({tag, "_busy"},  128'(ks_a.o_busy), 128'h1);
      chk({tag, "_round"}, 128'(ks_a.o_roundNumber), 128'(r));
      if (exp_ok[r]) chk({tag, "_key"}, ks_a.o_roundKey, exp_rk[r]);
      if (r == inj_r) begin
        ks_a.i_start = 1'b1;
        ks_a.i_key   = KEY_JUNK;
      end else begin
        ks_a.i_start = 1'b0;
      end
      tick();
    end
    ks_a.i_start = 1'b0;
    chk({tag, "_done"},     128'(ks_a.o_done), 128'h1);
    chk({tag, "_finvalid"}, 128'(ks_a.o_roundKeyValid), 128'h0);
    chk({tag, "_finbusy"},  128'(ks_a.o_busy), 128'h0);
  endtask

  task automatic load_fips();
    for (int r = 0; r <= 10; r++) begin
      exp_rk[r] = fips_rk[r];
      exp_ok[r] = 1'b1;
    end
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    ks_a.i_start = 1'b0; ks_a.i_key = '0; ks_a.i_roundKeyReady = 1'b0;
    ks_b.i_start = 1'b0; ks_b.i_key = '0; ks_b.i_roundKeyReady = 1'b0;

    // reset
    i_reset = 1'b1;
    tick();
    tick();
    chk_idle_a("reset");
    i_reset = 1'b0;
    tick();

    // 1: FIPS key, ready tied high, rounds on consecutive cycles
    load_fips();
    start_a(KEY_FIPS);
    walk_a("s1", 0, -1);
    tick();
    chk("s1_done_low", 128'(ks_a.o_done), 128'h0);

    // 2: random ready; scoreboard queue holds the remaining round keys
    for (int r = 0; r <= 10; r++) exp_q.push_back(fips_rk[r]);
    start_a(KEY_FIPS);
    begin
      int r;
      int cyc;
      logic rdy;
      r = 0;
      cyc = 0;
      while (r <= 10 && cyc < 300) begin
        rdy = 1'($urandom_range(0, 1));
        ks_a.i_roundKeyReady = rdy;
        chk("s2_valid", 128'(ks_a.o_roundKeyValid), 128'h1);
        chk("s2_round", 128'(ks_a.o_roundNumber), 128'(r));
        chk("s2_key", ks_a.o_roundKey, exp_q[0]);
        tick();
        if (rdy) begin
          void'(exp_q.pop_front());
          r++;
        end
        cyc++;
      end
      chk("s2_timeout", 128'(r), 128'd11);
      if (r == 11) chk("s2_done", 128'(ks_a.o_done), 128'h1);
    end
    exp_q.delete();
    tick();

    // 3: stray start with another key during EMIT is ignored
    start_a(KEY_FIPS);
    walk_a("s3", 0, 3);
    tick();

    // 4: reset at round 5 aborts; restart begins at round 0 with rcon 01
    start_a(KEY_FIPS);
    ks_a.i_roundKeyReady = 1'b1;
    for (int r = 0; r < 5; r++) tick();
    chk("s4_round5", 128'(ks_a.o_roundNumber), 128'd5);
    chk("s4_key5", ks_a.o_roundKey, fips_rk[5]);
    i_reset = 1'b1;
    tick();
    chk_idle_a("s4_rst");
    i_reset = 1'b0;
    tick();
    chk("s4_nodone", 128'(ks_a.o_done), 128'h0);
    chk("s4_novalid", 128'(ks_a.o_roundKeyValid), 128'h0);
    start_a(KEY_FIPS);
    walk_a("s4", 0, -1);

    // 5: back-to-back start in the IDLE cycle right after done
    tick();
    for (int r = 0; r <= 10; r++) exp_ok[r] = 1'b0;
    exp_rk[0]  = KEY_SEQ;                                 exp_ok[0]  = 1'b1;
    exp_rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;   exp_ok[1]  = 1'b1;
    exp_rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;   exp_ok[10] = 1'b1;
    start_a(KEY_SEQ);
    walk_a("s5", 0, -1);
    tick();

    // 6: round 0 suppressed; first key is round 1 one cycle after start
    ks_b.i_key = KEY_FIPS;
    ks_b.i_start = 1'b1;
    ks_b.i_roundKeyReady = 1'b1;
    tick();
    ks_b.i_start = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      chk("s6_valid", 128'(ks_b.o_roundKeyValid), 128'h1);
      chk("s6_round", 128'(ks_b.o_roundNumber), 128'(r));
      chk("s6_key", ks_b.o_roundKey, fips_rk[r]);
      tick();
    end
    chk("s6_done", 128'(ks_b.o_done), 128'h1);
    chk("s6_finvalid", 128'(ks_b.o_roundKeyValid), 128'h0);
    tick();
    chk("s6_done_low", 128'(ks_b.o_done), 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
